// File: rtl/arith_word_sequencer.sv
// arith_word_sequencer
// Runs one NBYTES-wide arithmetic operation through an external 8-bit
// combinational arithmetic unit, one byte per clock and LSB first. The carry
// (or borrow) is chained between bytes. The unit's output bytes are gathered
// into a full-width result with carry-out and signed-overflow flags.
//
// Handshake: start is a level request. It is sampled at a rising edge only
// while the block is not in RUN (IDLE or DONE). An accepted request latches
// a/b/op/cin. The block then raises busy for NBYTES cycles and pulses done
// for exactly one cycle. A start seen during RUN is dropped, not queued.
// result/cout/ovf change only at completion or reset.
module arith_word_sequencer #(
   parameter int NBYTES = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [1:0]          op,
   input  logic                cin,
   input  logic [8*NBYTES-1:0] a,
   input  logic [8*NBYTES-1:0] b,
   output logic                busy,
   output logic                done,
   output logic [8*NBYTES-1:0] result,
   output logic                cout,
   output logic                ovf,
   output logic [7:0]          au_x,
   output logic [7:0]          au_y,
   output logic                au_cin,
   output logic                au_sel0,
   output logic                au_sel1,
   input  logic [7:0]          au_f,
   input  logic                au_cout
);

   localparam int W  = 8 * NBYTES;
   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

   // op[1:0] encoding as seen by the unit (sel1, sel0)
   localparam logic [1:0] OP_INC = 2'b00;  // x + cin
   localparam logic [1:0] OP_ADD = 2'b01;  // x + y + cin
   localparam logic [1:0] OP_SUB = 2'b10;  // x - y - borrow
   localparam logic [1:0] OP_DEC = 2'b11;  // x - 1 + cin

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t          state;
   state_t          state_nxt;

   // Latched request
   logic [W-1:0]    a_lat;
   logic [W-1:0]    b_lat;
   logic [1:0]      op_lat;
   logic            cin_lat;

   // Sequencing
   logic [IW-1:0]   idx;
   logic            carry;        // carry (or borrow for subtract) into byte idx
   logic [W-1:0]    shadow;       // bytes collected so far

   // Decoded control
   logic            accept;
   logic            last_byte;
   logic [W-1:0]    final_word;
   logic            eff_y_msb;
   logic            ovf_nxt;
   logic            carry_nxt;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and status outputs
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (idx == LAST_IDX) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            // done lasts this one cycle whether or not a new start arrives
            done = 1'b1;
            if (start) begin
               accept    = 1'b1;
               state_nxt = S_RUN;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Unit drive: the current byte while in RUN, all zero otherwise
   always_comb begin
      au_x    = 8'h00;
      au_y    = 8'h00;
      au_cin  = 1'b0;
      au_sel0 = 1'b0;
      au_sel1 = 1'b0;
      if (state == S_RUN) begin
         au_x    = a_lat[{idx, 3'b000} +: 8];
         au_y    = b_lat[{idx, 3'b000} +: 8];
         au_sel0 = op_lat[0];
         au_sel1 = op_lat[1];
         au_cin  = (idx == '0) ? cin_lat : carry;
      end
   end

   // Completion data: final word, carry for next byte, signed overflow
   always_comb begin
      last_byte  = (state == S_RUN) && (idx == LAST_IDX);
      final_word = shadow;
      final_word[{idx, 3'b000} +: 8] = au_f;

      // The unit inverts cin internally for subtract, so the chained value
      // for subtract is the borrow, i.e. the inverted carry-out.
      carry_nxt = (op_lat == OP_SUB) ? ~au_cout : au_cout;

      // Sign of the effective second addend seen by the unit
      case (op_lat)
         OP_INC:  eff_y_msb = 1'b0;
         OP_ADD:  eff_y_msb = b_lat[W-1];
         OP_SUB:  eff_y_msb = ~b_lat[W-1];
         OP_DEC:  eff_y_msb = 1'b1;
         default: eff_y_msb = 1'b0;
      endcase

      ovf_nxt = (a_lat[W-1] == eff_y_msb) && (final_word[W-1] != a_lat[W-1]);
   end

   // Request latch, byte sequencing and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_lat   <= '0;
         b_lat   <= '0;
         op_lat  <= 2'b00;
         cin_lat <= 1'b0;
         idx     <= '0;
         carry   <= 1'b0;
         shadow  <= '0;
         result  <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else if (accept) begin
         a_lat   <= a;
         b_lat   <= b;
         op_lat  <= op;
         cin_lat <= cin;
         idx     <= '0;
         carry   <= 1'b0;
      end else if (state == S_RUN) begin
         shadow[{idx, 3'b000} +: 8] <= au_f;
         carry <= carry_nxt;
         if (last_byte) begin
            result <= final_word;
            cout   <= au_cout;
            ovf    <= ovf_nxt;
            idx    <= '0;
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_arith_word_sequencer.sv
// Testbench for arith_word_sequencer. It includes a behavioural model of the
// 8-bit arithmetic unit that drives au_f/au_cout. Expected word results come
// from full-width signed/unsigned arithmetic.
module tb_arith_word_sequencer;

   localparam int NBYTES = 4;
   localparam int W      = 8 * NBYTES;

   // Clock and reset
   logic         clk = 1'b0;
   logic         rst;
   always #5 clk = ~clk;

   logic         start;
   logic [1:0]   op;
   logic         cin;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;
   logic [7:0]   au_x;
   logic [7:0]   au_y;
   logic         au_cin;
   logic         au_sel0;
   logic         au_sel1;
   logic [7:0]   au_f;
   logic         au_cout;

   int checks = 0;
   int errors = 0;

   arith_word_sequencer #(.NBYTES(NBYTES)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op      (op),
      .cin     (cin),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .cout    (cout),
      .ovf     (ovf),
      .au_x    (au_x),
      .au_y    (au_y),
      .au_cin  (au_cin),
      .au_sel0 (au_sel0),
      .au_sel1 (au_sel1),
      .au_f    (au_f),
      .au_cout (au_cout)
   );

   // Combinational 8-bit arithmetic unit (subtract inverts cin internally)
   logic [8:0] au_sum;
   always_comb begin
      au_sum = 9'h000;
      case ({au_sel1, au_sel0})
         2'b00: au_sum = {1'b0, au_x} + {8'h00, au_cin};
         2'b01: au_sum = {1'b0, au_x} + {1'b0, au_y} + {8'h00, au_cin};
         2'b10: au_sum = {1'b0, au_x} + {1'b0, ~au_y} + {8'h00, ~au_cin};
         default: au_sum = {1'b0, au_x} + 9'h0FF + {8'h00, au_cin};
      endcase
      au_f    = au_sum[7:0];
      au_cout = au_sum[8];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Word-level reference: plain arithmetic on the whole operands
   task automatic model(input logic [1:0] op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                        input logic cin_i, output logic [W-1:0] r, output logic c, output logic v);
      longint sa, sb, t, maxv, minv;
      logic [W:0] u;
      sa   = longint'($signed(a_i));
      sb   = longint'($signed(b_i));
      maxv = (longint'(1) <<< (W - 1)) - 1;
      minv = -(longint'(1) <<< (W - 1));
      u    = '0;
      case (op_i)
         2'b00: begin
            u = {1'b0, a_i} + {{W{1'b0}}, cin_i};
            r = u[W-1:0]; c = u[W];
            t = sa + longint'(cin_i);
         end
         2'b01: begin
            u = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
            r = u[W-1:0]; c = u[W];
            t = sa + sb + longint'(cin_i);
         end
         2'b10: begin
            r = a_i - b_i - {{(W-1){1'b0}}, cin_i};
            c = ({1'b0, a_i} >= ({1'b0, b_i} + {{W{1'b0}}, cin_i}));
            t = sa - sb - longint'(cin_i);
         end
         default: begin
            r = a_i - {{(W-1){1'b0}}, 1'b1} + {{(W-1){1'b0}}, cin_i};
            c = (a_i != '0) || cin_i;
            t = sa - 1 + longint'(cin_i);
         end
      endcase
      v = (t > maxv) || (t < minv);
   endtask

   // Driver: one full operation with timing, handshake and result checks
   task automatic run_op(input logic [1:0] op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                         input logic cin_i, output logic [NBYTES-1:0] cin_seq);
      logic [W-1:0] er;
      logic         ec, ev;
      model(op_i, a_i, b_i, cin_i, er, ec, ev);
      cin_seq = '0;
      @(negedge clk);
      start = 1'b1; op = op_i; a = a_i; b = b_i; cin = cin_i;
      for (int i = 0; i < NBYTES; i++) begin
         @(negedge clk);
         start = 1'b0;
         check("run_busy", 64'(busy), 64'd1);
         check("run_done", 64'(done), 64'd0);
         if (i == 0) check("run_sel", 64'({au_sel1, au_sel0}), 64'(op_i));
         cin_seq[i] = au_cin;
      end
      @(negedge clk);
      check("done_pulse", 64'(done), 64'd1);
      check("done_busy", 64'(busy), 64'd0);
      check("result", 64'(result), 64'(er));
      check("cout", 64'(cout), 64'(ec));
      check("ovf", 64'(ovf), 64'(ev));
      @(negedge clk);
      check("done_once", 64'(done), 64'd0);
      check("held_result", 64'(result), 64'(er));
   endtask

   logic [NBYTES-1:0] seq;
   logic [W-1:0]      er1, er2, ra, rb;
   logic              ec1, ev1, ec2, ev2, rc;
   logic [1:0]        rop;

   // Main directed + random sequence
   initial begin
      rst = 1'b1; start = 1'b0; op = 2'b00; cin = 1'b0; a = '0; b = '0;
      #2;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      check("rst_flags", 64'({cout, ovf}), 64'd0);
      check("rst_au", 64'({au_x, au_y, au_cin, au_sel0, au_sel1}), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Plan 1..4: directed corner operations
      run_op(2'b01, 32'h000000FF, 32'h00000001, 1'b0, seq);
      check("p1_result", 64'(result), 64'h00000100);
      run_op(2'b10, 32'h00000000, 32'h00000001, 1'b0, seq);
      check("p2_cin_seq", 64'(seq), 64'b1110);
      check("p2_result", 64'({result, cout, ovf}), {30'd0, 32'hFFFFFFFF, 2'b00});
      run_op(2'b10, 32'h80000000, 32'h00000001, 1'b0, seq);
      check("p2b_result", 64'({result, cout, ovf}), {30'd0, 32'h7FFFFFFF, 2'b11});
      run_op(2'b11, 32'h80000000, 32'h00000000, 1'b0, seq);
      check("p3_result", 64'({result, cout, ovf}), {30'd0, 32'h7FFFFFFF, 2'b11});
      run_op(2'b00, 32'hFFFFFFFF, 32'h12345678, 1'b1, seq);
      check("p3b_result", 64'({result, cout, ovf}), {30'd0, 32'h00000000, 2'b10});
      run_op(2'b01, 32'h7FFFFFFF, 32'h00000001, 1'b0, seq);
      check("p4_result", 64'({result, cout, ovf}), {30'd0, 32'h80000000, 2'b01});
      run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, seq);
      check("p4b_result", 64'({result, cout, ovf}), {30'd0, 32'hFFFFFFFF, 2'b10});

      // Plan 5: start during RUN is ignored, start during DONE restarts
      model(2'b01, 32'h11223344, 32'h01010101, 1'b0, er1, ec1, ev1);
      model(2'b10, 32'h00000005, 32'h00000007, 1'b1, er2, ec2, ev2);
      @(negedge clk);
      start = 1'b1; op = 2'b01; a = 32'h11223344; b = 32'h01010101; cin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; op = 2'b11; a = 32'hDEADBEEF; b = 32'hCAFEF00D; cin = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("p5_busy_ignored", 64'(busy), 64'd1);
      @(negedge clk);
      @(negedge clk);
      check("p5_done", 64'(done), 64'd1);
      check("p5_result", 64'({result, cout, ovf}), {30'd0, er1, ec1, ev1});
      start = 1'b1; op = 2'b10; a = 32'h00000005; b = 32'h00000007; cin = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("p5_restart_busy", 64'(busy), 64'd1);
      check("p5_done_one_cycle", 64'(done), 64'd0);
      repeat (3) begin
         @(negedge clk);
         check("p5_run2_done", 64'(done), 64'd0);
      end
      @(negedge clk);
      check("p5_done2", 64'(done), 64'd1);
      check("p5_result2", 64'({result, cout, ovf}), {30'd0, er2, ec2, ev2});
      @(negedge clk);
      check("p5_done2_once", 64'(done), 64'd0);

      // Plan 6: asynchronous reset mid-sequence
      @(negedge clk);
      start = 1'b1; op = 2'b01; a = 32'h0F0F0F0F; b = 32'h10101010; cin = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("p6_busy_before", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      check("p6_rst_busy", 64'(busy), 64'd0);
      check("p6_rst_result", 64'(result), 64'd0);
      check("p6_rst_au", 64'({au_x, au_y, au_cin, au_sel0, au_sel1}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("p6_no_done", 64'({done, busy}), 64'd0);
      end
      run_op(2'b01, 32'h0F0F0F0F, 32'h10101010, 1'b1, seq);

      // Randomized operations against the word-level model
      for (int n = 0; n < 40; n++) begin
         rop = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 4))
            0: ra = 32'h00000000;
            1: ra = 32'hFFFFFFFF;
            2: ra = 32'h7FFFFFFF;
            3: ra = 32'h80000000;
            default: ra = $urandom;
         endcase
         rb = ($urandom_range(0, 3) == 0) ? 32'h00000001 : $urandom;
         rc = 1'($urandom_range(0, 1));
         run_op(rop, ra, rb, rc, seq);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
